// File: rtl/program_counter_unit_if.sv
// -----------------------------------------------------------------------------
// program_counter_unit_if
//   Signal bundle between the IF-stage PC unit and its surroundings: debug
//   unit, hazard unit, decode, the PC+4 adder and instruction memory.
//
//   master : the surroundings. Drive the requests and redirect inputs and
//            observe the PC and status outputs.
//   slave  : program_counter_unit. Consumes the requests and produces the
//            PC and status outputs.
//
//   Handshake: o_fetch_en acts as the "accept" strobe. It is high in any cycle
//   where the PC unit advances. In that cycle, the selected next-PC candidate
//   is consumed, and o_PC shows the new value after the next rising edge.
//   The redirect inputs (i_jr/i_jump/i_branch with their addresses) and
//   i_sum_pc are only looked at while o_fetch_en is high. Outside those
//   cycles, they are ignored and o_PC holds.
//
//   o_state is the FSM state, exposed for debug/observation
//   (0=IDLE, 1=RUN, 2=STEP, 3=HALTED).
// -----------------------------------------------------------------------------
interface program_counter_unit_if #(
    parameter int NBITS    = 32,
    parameter int CNT_BITS = 32
);
    logic                i_enable;
    logic                i_step;
    logic                i_stall;
    logic                i_halt;
    logic [NBITS-1:0]    i_sum_pc;
    logic                i_branch;
    logic [NBITS-1:0]    i_branch_addr;
    logic                i_jump;
    logic [NBITS-1:0]    i_jump_addr;
    logic                i_jr;
    logic [NBITS-1:0]    i_jr_addr;
    logic [NBITS-1:0]    o_PC;
    logic                o_fetch_en;
    logic                o_halted;
    logic                o_misaligned;
    logic [CNT_BITS-1:0] o_cycles;
    logic [1:0]          o_state;

    modport master (
        output i_enable, i_step, i_stall, i_halt, i_sum_pc,
               i_branch, i_branch_addr, i_jump, i_jump_addr, i_jr, i_jr_addr,
        input  o_PC, o_fetch_en, o_halted, o_misaligned, o_cycles, o_state
    );

    modport slave (
        input  i_enable, i_step, i_stall, i_halt, i_sum_pc,
               i_branch, i_branch_addr, i_jump, i_jump_addr, i_jr, i_jr_addr,
        output o_PC, o_fetch_en, o_halted, o_misaligned, o_cycles, o_state
    );
endinterface

// File: rtl/program_counter_unit.sv
// -----------------------------------------------------------------------------
// program_counter_unit
//   PC register and next-PC selection for the IF stage of the MIPS pipeline.
//   A small run-control FSM lets the debug unit run, single-step or freeze
//   the front end. Decode can also stop the front end for good with HALT.
//
//   Ports:
//     i_clk    : clock; all state updates happen on the rising edge
//     i_reset  : asynchronous, active-high reset
//     bus      : program_counter_unit_if.slave
//                requests : i_enable, i_step, i_stall, i_halt
//                next PC  : i_sum_pc, i_branch/_addr, i_jump/_addr, i_jr/_addr
//                outputs  : o_PC, o_fetch_en, o_halted, o_misaligned,
//                           o_cycles, o_state (debug view of the FSM)
//
//   Parameters:
//     NBITS    : PC / address width
//     CNT_BITS : width of the saturating active-cycle counter
//     RESET_PC : PC loaded on reset (word aligned)
// -----------------------------------------------------------------------------
module program_counter_unit #(
    parameter int               NBITS    = 32,
    parameter int               CNT_BITS = 32,
    parameter logic [NBITS-1:0] RESET_PC = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    program_counter_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [NBITS-1:0]    pc;
    logic                misaligned;
    logic [CNT_BITS-1:0] cycles;

    logic                active;
    logic                advance;
    logic                redirect;
    logic [NBITS-1:0]    target;
    logic [NBITS-1:0]    pc_next;

    // -------------------------------------------------------------------------
    // Advance qualification.
    // HALT beats a stall: it blocks the advance just like a stall does, and
    // the FSM also moves to HALTED.
    // -------------------------------------------------------------------------
    always_comb begin
        active  = (state == S_RUN) || (state == S_STEP);
        advance = active && !bus.i_stall && !bus.i_halt;
    end

    // -------------------------------------------------------------------------
    // Next-PC selection. Priority order is jr > jump > branch > sequential.
    // The low two bits are always cleared, which keeps o_PC word aligned.
    // Only a redirect target can raise the misaligned flag. The adder output
    // is assumed aligned.
    // -------------------------------------------------------------------------
    always_comb begin
        redirect = 1'b1;
        target   = bus.i_sum_pc;
        if (bus.i_jr) begin
            target = bus.i_jr_addr;
        end else if (bus.i_jump) begin
            target = bus.i_jump_addr;
        end else if (bus.i_branch) begin
            target = bus.i_branch_addr;
        end else begin
            redirect = 1'b0;
        end
        pc_next = {target[NBITS-1:2], 2'b00};
    end

    // -------------------------------------------------------------------------
    // Run-control FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                // enable wins over step when both are requested
                if (bus.i_enable) begin
                    state_next = S_RUN;
                end else if (bus.i_step) begin
                    state_next = S_STEP;
                end
            end
            S_RUN: begin
                if (bus.i_halt) begin
                    state_next = S_HALTED;
                end else if (!bus.i_enable) begin
                    state_next = S_IDLE;
                end
            end
            S_STEP: begin
                // One instruction only. A stall holds us here until the
                // advance actually happens.
                if (bus.i_halt) begin
                    state_next = S_HALTED;
                end else if (advance) begin
                    state_next = S_IDLE;
                end
            end
            S_HALTED: begin
                // Only reset leaves HALTED.
                state_next = S_HALTED;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Run-control FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // PC register and misaligned-target pulse.
    // The misaligned flag is rewritten every cycle, so it is high for exactly
    // one cycle after the offending redirect.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc         <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            misaligned <= advance && redirect && (target[1:0] != 2'b00);
            if (advance) begin
                pc <= pc_next;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Active-cycle counter. It counts every RUN/STEP cycle, stalled cycles
    // included, and saturates at all-ones instead of wrapping.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cycles <= '0;
        end else if (active && (cycles != {CNT_BITS{1'b1}})) begin
            cycles <= cycles + CNT_BITS'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.o_PC         = pc;
        bus.o_fetch_en   = advance;
        bus.o_halted     = (state == S_HALTED);
        bus.o_misaligned = misaligned;
        bus.o_cycles     = cycles;
        bus.o_state      = state;
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// -----------------------------------------------------------------------------
// tb_program_counter_unit
//   Directed, table-driven bench for program_counter_unit, plus hand-written
//   sequences for reset, asynchronous reset and counter saturation.
//   A second instance with CNT_BITS=4 covers saturation.
// -----------------------------------------------------------------------------
module tb_program_counter_unit;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic rst;
    logic rst2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    program_counter_unit_if #(.NBITS(32), .CNT_BITS(32)) bus ();
    program_counter_unit_if #(.NBITS(32), .CNT_BITS(4))  bus2 ();

    program_counter_unit #(.NBITS(32), .CNT_BITS(32), .RESET_PC(32'h0)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    program_counter_unit #(.NBITS(32), .CNT_BITS(4), .RESET_PC(32'h0)) dut2 (
        .i_clk   (clk),
        .i_reset (rst2),
        .bus     (bus2.slave)
    );

    // The second instance simply runs sequentially: the adder result is
    // looped back from its own PC.
    assign bus2.i_sum_pc = bus2.o_PC + 32'd4;

    // ---------------------------------------------------------------- scoreboard
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic        en;
        logic        step;
        logic        stall;
        logic        halt;
        logic [31:0] sum;
        logic        br;
        logic [31:0] br_a;
        logic        j;
        logic [31:0] j_a;
        logic        jr;
        logic [31:0] jr_a;
        logic        exp_fetch;   // combinational, before the edge
        logic [31:0] exp_pc;      // after the edge
        logic        exp_mis;
        logic [1:0]  exp_state;
        logic [31:0] exp_cyc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic en, input logic step, input logic stall, input logic halt,
        input logic [31:0] sum,
        input logic br, input logic [31:0] br_a,
        input logic j,  input logic [31:0] j_a,
        input logic jr, input logic [31:0] jr_a,
        input logic exp_fetch, input logic [31:0] exp_pc, input logic exp_mis,
        input logic [1:0] exp_state, input logic [31:0] exp_cyc);
        vec_t v;
        v.en = en; v.step = step; v.stall = stall; v.halt = halt; v.sum = sum;
        v.br = br; v.br_a = br_a; v.j = j; v.j_a = j_a; v.jr = jr; v.jr_a = jr_a;
        v.exp_fetch = exp_fetch; v.exp_pc = exp_pc; v.exp_mis = exp_mis;
        v.exp_state = exp_state; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic drive_idle();
        bus.i_enable = 0; bus.i_step = 0; bus.i_stall = 0; bus.i_halt = 0;
        bus.i_sum_pc = 0; bus.i_branch = 0; bus.i_branch_addr = 0;
        bus.i_jump = 0; bus.i_jump_addr = 0; bus.i_jr = 0; bus.i_jr_addr = 0;
    endtask

    // Inputs are driven 1 time unit after the rising edge. Combinational
    // outputs are checked 1 unit later. Registered outputs are checked
    // 1 unit after the next rising edge.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        bus.i_enable = v.en; bus.i_step = v.step; bus.i_stall = v.stall;
        bus.i_halt = v.halt; bus.i_sum_pc = v.sum;
        bus.i_branch = v.br; bus.i_branch_addr = v.br_a;
        bus.i_jump = v.j; bus.i_jump_addr = v.j_a;
        bus.i_jr = v.jr; bus.i_jr_addr = v.jr_a;
        #1;
        check({tag, " fetch_en"}, 64'(bus.o_fetch_en), 64'(v.exp_fetch));
        @(posedge clk); #1;
        check({tag, " pc"},         64'(bus.o_PC),         64'(v.exp_pc));
        check({tag, " misaligned"}, 64'(bus.o_misaligned), 64'(v.exp_mis));
        check({tag, " state"},      64'(bus.o_state),      64'(v.exp_state));
        check({tag, " halted"},     64'(bus.o_halted),     64'(v.exp_state == S_HALTED));
        check({tag, " cycles"},     64'(bus.o_cycles),     64'(v.exp_cyc));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc"},         64'(bus.o_PC),         64'h0);
        check({tag, " state"},      64'(bus.o_state),      64'(S_IDLE));
        check({tag, " halted"},     64'(bus.o_halted),     64'h0);
        check({tag, " misaligned"}, 64'(bus.o_misaligned), 64'h0);
        check({tag, " fetch_en"},   64'(bus.o_fetch_en),   64'h0);
        check({tag, " cycles"},     64'(bus.o_cycles),     64'h0);
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        logic [31:0] exp_pc;

        // Columns: en step stall halt | sum | br br_a | j j_a | jr jr_a ||
        //          fetch pc mis state cycles
        tbl.push_back(mk(1,0,0,0, 32'h4,   0,0,       0,0,           0,0,     0, 32'h0,   0, S_RUN,  0));
        tbl.push_back(mk(1,0,0,0, 32'h4,   0,0,       0,0,           0,0,     1, 32'h4,   0, S_RUN,  1));
        tbl.push_back(mk(1,0,0,0, 32'h8,   0,0,       0,0,           0,0,     1, 32'h8,   0, S_RUN,  2));
        tbl.push_back(mk(1,0,0,0, 32'hC,   0,0,       0,0,           0,0,     1, 32'hC,   0, S_RUN,  3));
        tbl.push_back(mk(1,0,0,0, 32'h10,  0,0,       0,0,           0,0,     1, 32'h10,  0, S_RUN,  4));
        // stall for two cycles at 0x10; the counter keeps counting
        tbl.push_back(mk(1,0,1,0, 32'h14,  0,0,       0,0,           0,0,     0, 32'h10,  0, S_RUN,  5));
        tbl.push_back(mk(1,0,1,0, 32'h14,  0,0,       0,0,           0,0,     0, 32'h10,  0, S_RUN,  6));
        tbl.push_back(mk(1,0,0,0, 32'h14,  0,0,       0,0,           0,0,     1, 32'h14,  0, S_RUN,  7));
        // all three redirects at once: jr wins
        tbl.push_back(mk(1,0,0,0, 32'h18,  1,32'hC0,  1,32'h80,      1,32'h40, 1, 32'h40,  0, S_RUN,  8));
        // misaligned branch target, then a clean cycle
        tbl.push_back(mk(1,0,0,0, 32'h44,  1,32'h103, 0,0,           0,0,     1, 32'h100, 1, S_RUN,  9));
        tbl.push_back(mk(1,0,0,0, 32'h104, 0,0,       0,0,           0,0,     1, 32'h104, 0, S_RUN, 10));
        // misaligned jump over a branch
        tbl.push_back(mk(1,0,0,0, 32'h108, 1,32'h500, 1,32'h202,     0,0,     1, 32'h200, 1, S_RUN, 11));
        // enable dropped: the RUN cycle still advances, then IDLE
        tbl.push_back(mk(0,0,0,0, 32'h204, 0,0,       0,0,           0,0,     1, 32'h204, 0, S_IDLE, 12));
        // IDLE ignores redirects
        tbl.push_back(mk(0,0,0,0, 32'h204, 0,0,       0,0,           1,32'h300, 0, 32'h204, 0, S_IDLE, 12));
        // single step
        tbl.push_back(mk(0,1,0,0, 32'h208, 0,0,       0,0,           0,0,     0, 32'h204, 0, S_STEP, 12));
        tbl.push_back(mk(0,0,0,0, 32'h208, 0,0,       0,0,           0,0,     1, 32'h208, 0, S_IDLE, 13));
        tbl.push_back(mk(0,0,0,0, 32'h20C, 0,0,       0,0,           0,0,     0, 32'h208, 0, S_IDLE, 13));
        // single step delayed by a stall
        tbl.push_back(mk(0,1,0,0, 32'h20C, 0,0,       0,0,           0,0,     0, 32'h208, 0, S_STEP, 13));
        tbl.push_back(mk(0,0,1,0, 32'h20C, 0,0,       0,0,           0,0,     0, 32'h208, 0, S_STEP, 14));
        tbl.push_back(mk(0,0,0,0, 32'h20C, 0,0,       0,0,           0,0,     1, 32'h20C, 0, S_IDLE, 15));
        // enable and step together: RUN
        tbl.push_back(mk(1,1,0,0, 32'h210, 0,0,       0,0,           0,0,     0, 32'h20C, 0, S_RUN, 15));
        // wrap at 2^32
        tbl.push_back(mk(1,0,0,0, 32'h210, 0,0,       1,32'hFFFFFFFC, 0,0,    1, 32'hFFFFFFFC, 0, S_RUN, 16));
        tbl.push_back(mk(1,0,0,0, 32'h0,   0,0,       0,0,           0,0,     1, 32'h0,   0, S_RUN, 17));
        // halt together with a stall: halt wins, PC frozen
        tbl.push_back(mk(1,0,1,1, 32'h4,   0,0,       0,0,           0,0,     0, 32'h0,   0, S_HALTED, 18));
        tbl.push_back(mk(1,1,0,0, 32'h4,   0,0,       0,0,           1,32'h40, 0, 32'h0,   0, S_HALTED, 18));
        tbl.push_back(mk(0,1,0,0, 32'h4,   0,0,       0,0,           0,0,     0, 32'h0,   0, S_HALTED, 18));

        drive_idle();
        bus2.i_enable = 0; bus2.i_step = 0; bus2.i_stall = 0; bus2.i_halt = 0;
        bus2.i_branch = 0; bus2.i_branch_addr = 0; bus2.i_jump = 0;
        bus2.i_jump_addr = 0; bus2.i_jr = 0; bus2.i_jr_addr = 0;
        rst  = 1'b1;
        rst2 = 1'b1;
        #12;
        check_reset_state("reset");
        @(posedge clk); #1;
        rst  = 1'b0;
        rst2 = 1'b0;

        // -------- table
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // -------- reset releases HALTED
        rst = 1'b1;
        #1;
        check_reset_state("halt_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();

        // -------- async reset mid-cycle during RUN at PC=0x24
        bus.i_enable = 1'b1;
        exp_pc = 32'h0;
        bus.i_sum_pc = exp_pc + 32'd4;
        @(posedge clk); #1;          // IDLE -> RUN
        for (int k = 0; k < 9; k++) begin
            bus.i_sum_pc = exp_pc + 32'd4;
            @(posedge clk); #1;
            exp_pc = exp_pc + 32'd4;
        end
        check("run pc 0x24", 64'(bus.o_PC), 64'h24);
        check("run cycles",  64'(bus.o_cycles), 64'd9);
        #2;                          // mid-cycle, away from any edge
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();

        // -------- saturating counter on the CNT_BITS=4 instance
        bus2.i_enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
        end
        check("cnt4 at 15", 64'(bus2.o_cycles), 64'd15);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check("cnt4 saturated", 64'(bus2.o_cycles), 64'd15);
        check("cnt4 pc",        64'(bus2.o_PC),     64'h4C);
        bus2.i_enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the directed sequence is short, so this should never fire.
    initial begin
        #20000;
        bad++;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
